timer_counter: RTL and testbench



---
 rtl/timer_pkg.sv | 34 +++
 rtl/timer_tick_gen.sv | 67 ++++++
 rtl/timer_counter.sv | 147 ++++++++++++++
 tb/tb_timer_counter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants and types for the timer counting core.
// Contents:
//   CNT_UP / CNT_UPDOWN     count_mode encodings
//   CLK_INT / CLK_EXT       clock_select encodings
//   EDGE_RISE / EDGE_FALL   edge_mode encodings
//   dir_e                   counting direction state
//   div_width()             width of the prescaler divider for a given field width
package timer_pkg;

    localparam int unsigned COUNTER_SIZE_DEF  = 32;
    localparam int unsigned PRESCALER_BIT_DEF = 3;

    localparam logic CNT_UP     = 1'b0;
    localparam logic CNT_UPDOWN = 1'b1;

    localparam logic CLK_INT = 1'b0;
    localparam logic CLK_EXT = 1'b1;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } dir_e;

    // Largest divide ratio is 2^(2^pb - 1), so the divider needs 2^pb - 1 bits.
    function automatic int unsigned div_width(input int unsigned pb);
        int unsigned w;
        w = (32'd1 << pb) - 32'd1;
        return (w == 0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/timer_tick_gen.sv
// Count-event generator: selects the internal clock or a synchronised external pin edge as the
// event source and divides events by 2^prescaler to produce the counter tick.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   ext_clk_i         asynchronous external count source
//   start_i           run enable; divider is held at zero while low
//   clock_select_i    event source (CLK_INT / CLK_EXT)
//   edge_mode_i       external edge polarity (EDGE_RISE / EDGE_FALL)
//   prescaler_i       divide exponent
//   clear_i           clears the divider (counter load)
//   tick_o            one-cycle count tick
module timer_tick_gen
    import timer_pkg::*;
#(
    parameter int unsigned PRESCALER_BIT = PRESCALER_BIT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ext_clk_i,
    input  logic                     start_i,
    input  logic                     clock_select_i,
    input  logic                     edge_mode_i,
    input  logic [PRESCALER_BIT-1:0] prescaler_i,
    input  logic                     clear_i,
    output logic                     tick_o
);

    localparam int unsigned DivW = div_width(PRESCALER_BIT);

    logic            sync1_q, sync2_q, hist_q;
    logic            ext_ev_q, ext_ev_d;
    logic            event_w;
    logic [DivW-1:0] div_q, div_d, div_lim;

    always_comb begin
        ext_ev_d = (edge_mode_i == EDGE_FALL) ? (hist_q & ~sync2_q) : (~hist_q & sync2_q);
        event_w  = (clock_select_i == CLK_EXT) ? ext_ev_q : 1'b1;
        // 2^prescaler - 1 as a right-aligned mask.
        div_lim  = {DivW{1'b1}} >> (DivW - 32'(prescaler_i));
        // >= rather than == so lowering the prescaler mid-count never stalls.
        tick_o   = start_i & event_w & (div_q >= div_lim);

        div_d = div_q;
        if (!start_i || clear_i) begin
            div_d = '0;
        end else if (event_w) begin
            div_d = tick_o ? '0 : div_q + DivW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            hist_q   <= 1'b0;
            ext_ev_q <= 1'b0;
            div_q    <= '0;
        end else begin
            sync1_q  <= ext_clk_i;
            sync2_q  <= sync1_q;
            hist_q   <= sync2_q;
            ext_ev_q <= ext_ev_d;
            div_q    <= div_d;
        end
    end

endmodule

// File: rtl/timer_counter.sv
// Timer counting core: up or up/down counter between configurable limits, with overflow and
// two compare events, and a toggle/PWM waveform output.
// Ports:
//   clk, rst                         system clock, synchronous active-high reset
//   ext_clk_i                        asynchronous external count source
//   start_i                          run enable
//   count_mode_i                     CNT_UP / CNT_UPDOWN
//   clock_select_i, edge_mode_i      event source and external edge polarity
//   force_free_i                     use full range instead of min/max
//   prescaler_i                      divide exponent (ratio 2^prescaler)
//   count_init_i, cnt_init_wr_i      load value and one-cycle load strobe
//   count_min_i, count_max_i         bottom/top limits
//   match_0_value_i, match_1_value_i compare values
//   pwm_mode_i, inv_i                output mode and polarity
//   count_o, dir_o                   current count and direction
//   overflow_o, match_0_o, match_1_o one-cycle event pulses
//   tmr_out_o                        waveform output
module timer_counter
    import timer_pkg::*;
#(
    parameter int unsigned COUNTER_SIZE  = COUNTER_SIZE_DEF,
    parameter int unsigned PRESCALER_BIT = PRESCALER_BIT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ext_clk_i,
    input  logic                     start_i,
    input  logic                     count_mode_i,
    input  logic                     clock_select_i,
    input  logic                     edge_mode_i,
    input  logic                     force_free_i,
    input  logic [PRESCALER_BIT-1:0] prescaler_i,
    input  logic [COUNTER_SIZE-1:0]  count_init_i,
    input  logic                     cnt_init_wr_i,
    input  logic [COUNTER_SIZE-1:0]  count_min_i,
    input  logic [COUNTER_SIZE-1:0]  count_max_i,
    input  logic [COUNTER_SIZE-1:0]  match_0_value_i,
    input  logic [COUNTER_SIZE-1:0]  match_1_value_i,
    input  logic                     pwm_mode_i,
    input  logic                     inv_i,
    output logic [COUNTER_SIZE-1:0]  count_o,
    output logic                     dir_o,
    output logic                     overflow_o,
    output logic                     match_0_o,
    output logic                     match_1_o,
    output logic                     tmr_out_o
);

    logic                    tick;
    logic [COUNTER_SIZE-1:0] top, bottom;
    logic [COUNTER_SIZE-1:0] count_q, count_d;
    dir_e                    dir_q, dir_d;
    logic                    overflow_q, overflow_d;
    logic                    match_0_q, match_0_d;
    logic                    match_1_q, match_1_d;
    logic                    out_raw_q, out_raw_d;

    timer_tick_gen #(
        .PRESCALER_BIT (PRESCALER_BIT)
    ) u_tick_gen (
        .clk            (clk),
        .rst            (rst),
        .ext_clk_i      (ext_clk_i),
        .start_i        (start_i),
        .clock_select_i (clock_select_i),
        .edge_mode_i    (edge_mode_i),
        .prescaler_i    (prescaler_i),
        .clear_i        (cnt_init_wr_i),
        .tick_o         (tick)
    );

    always_comb begin
        top    = force_free_i ? '1 : count_max_i;
        bottom = force_free_i ? '0 : count_min_i;

        count_d    = count_q;
        dir_d      = dir_q;
        overflow_d = 1'b0;
        match_0_d  = 1'b0;
        match_1_d  = 1'b0;

        if (cnt_init_wr_i) begin
            // Loads never raise overflow or match.
            count_d = count_init_i;
            dir_d   = DirUp;
        end else if (tick) begin
            if (count_mode_i == CNT_UP) begin
                dir_d = DirUp;
                if (count_q >= top) begin
                    count_d    = bottom;
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + COUNTER_SIZE'(1);
                end
            end else if (top == bottom) begin
                // Degenerate range: hold and report a turnaround on every tick.
                dir_d      = DirUp;
                overflow_d = 1'b1;
            end else if (dir_q == DirUp) begin
                if (count_q >= top) begin
                    count_d    = count_q - COUNTER_SIZE'(1);
                    dir_d      = DirDown;
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + COUNTER_SIZE'(1);
                end
            end else begin
                if (count_q <= bottom) begin
                    count_d = count_q + COUNTER_SIZE'(1);
                    dir_d   = DirUp;
                end else begin
                    count_d = count_q - COUNTER_SIZE'(1);
                end
            end
            match_0_d = (count_d == match_0_value_i);
            match_1_d = (count_d == match_1_value_i);
        end

        out_raw_d = pwm_mode_i ? (count_d < match_0_value_i) : (out_raw_q ^ match_0_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            dir_q      <= DirUp;
            overflow_q <= 1'b0;
            match_0_q  <= 1'b0;
            match_1_q  <= 1'b0;
            out_raw_q  <= 1'b0;
        end else begin
            count_q    <= count_d;
            dir_q      <= dir_d;
            overflow_q <= overflow_d;
            match_0_q  <= match_0_d;
            match_1_q  <= match_1_d;
            out_raw_q  <= out_raw_d;
        end
    end

    assign count_o    = count_q;
    assign dir_o      = (dir_q == DirDown);
    assign overflow_o = overflow_q;
    assign match_0_o  = match_0_q;
    assign match_1_o  = match_1_q;
    assign tmr_out_o  = out_raw_q ^ inv_i;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: the driver advances a behavioural model at each negedge and
// queues the expected outputs; the monitor pops and compares after every posedge.
module tb_timer_counter;

    localparam int unsigned CW = 32;
    localparam int unsigned PB = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ext_clk = 1'b0;
    logic          start = 1'b0;
    logic          count_mode = 1'b0;
    logic          clock_select = 1'b0;
    logic          edge_mode = 1'b0;
    logic          force_free = 1'b0;
    logic [PB-1:0] prescaler = '0;
    logic [CW-1:0] count_init = '0;
    logic          cnt_init_wr = 1'b0;
    logic [CW-1:0] count_min = '0;
    logic [CW-1:0] count_max = '0;
    logic [CW-1:0] match0 = '0;
    logic [CW-1:0] match1 = '0;
    logic          pwm_mode = 1'b0;
    logic          inv = 1'b0;

    logic [CW-1:0] count;
    logic          dir, overflow, match_0, match_1, tmr_out;

    always #5 clk = ~clk;

    timer_counter #(
        .COUNTER_SIZE  (CW),
        .PRESCALER_BIT (PB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ext_clk_i       (ext_clk),
        .start_i         (start),
        .count_mode_i    (count_mode),
        .clock_select_i  (clock_select),
        .edge_mode_i     (edge_mode),
        .force_free_i    (force_free),
        .prescaler_i     (prescaler),
        .count_init_i    (count_init),
        .cnt_init_wr_i   (cnt_init_wr),
        .count_min_i     (count_min),
        .count_max_i     (count_max),
        .match_0_value_i (match0),
        .match_1_value_i (match1),
        .pwm_mode_i      (pwm_mode),
        .inv_i           (inv),
        .count_o         (count),
        .dir_o           (dir),
        .overflow_o      (overflow),
        .match_0_o       (match_0),
        .match_1_o       (match_1),
        .tmr_out_o       (tmr_out)
    );

    typedef struct packed {
        logic [CW-1:0] count;
        logic          dir;
        logic          ovf;
        logic          m0;
        logic          m1;
        logic          tout;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model state.
    logic [CW-1:0] m_count = '0;
    logic          m_dir = 1'b0, m_ovf = 1'b0, m_m0 = 1'b0, m_m1 = 1'b0, m_out = 1'b0;
    logic          m_ev = 1'b0;       // external event due at the next edge
    logic [3:0]    m_pins = '0;       // pin value at this edge ([0]) and the three before
    int unsigned   m_div = 0;         // events seen since the last tick

    // Per-cycle random knobs (percent, rst in per-mille).
    int pin_rate = 0, init_rate = 0, stop_rate = 0, rst_rate = 0;

    // Advances the model by one clock edge using the inputs now applied.
    task automatic model_step();
        logic          tick, ev;
        logic [CW-1:0] top, bot;
        int unsigned   lim;
        tick  = 1'b0;
        ev    = clock_select ? m_ev : 1'b1;
        m_ovf = 1'b0;
        m_m0  = 1'b0;
        m_m1  = 1'b0;
        if (rst) begin
            m_count = '0;
            m_dir   = 1'b0;
            m_div   = 0;
        end else if (cnt_init_wr) begin
            m_count = count_init;
            m_dir   = 1'b0;
            m_div   = 0;
        end else if (!start) begin
            m_div = 0;
        end else if (ev) begin
            lim = (32'd1 << prescaler) - 32'd1;
            if (m_div >= lim) begin
                tick  = 1'b1;
                m_div = 0;
            end else begin
                m_div++;
            end
        end
        if (tick) begin
            top = force_free ? {CW{1'b1}} : count_max;
            bot = force_free ? '0 : count_min;
            if (!count_mode) begin
                m_dir = 1'b0;
                if (m_count >= top) begin
                    m_count = bot;
                    m_ovf   = 1'b1;
                end else begin
                    m_count++;
                end
            end else if (top == bot) begin
                m_ovf = 1'b1;
                m_dir = 1'b0;
            end else if (!m_dir) begin
                if (m_count >= top) begin
                    m_count--;
                    m_dir = 1'b1;
                    m_ovf = 1'b1;
                end else begin
                    m_count++;
                end
            end else begin
                if (m_count <= bot) begin
                    m_count++;
                    m_dir = 1'b0;
                end else begin
                    m_count--;
                end
            end
            m_m0 = (m_count == match0);
            m_m1 = (m_count == match1);
        end
        if (rst) m_out = 1'b0;
        else if (pwm_mode) m_out = (m_count < match0);
        else m_out = m_out ^ m_m0;
        // External pin: an edge seen at the pin becomes a count event four edges later.
        m_pins = {m_pins[2:0], ext_clk};
        if (rst) m_pins = '0;
        if (rst) m_ev = 1'b0;
        else if (edge_mode) m_ev = m_pins[3] & ~m_pins[2];
        else m_ev = ~m_pins[3] & m_pins[2];
    endtask

    task automatic drive_cycle();
        if (pin_rate > 0 && int'($urandom_range(99)) < pin_rate) ext_clk = ~ext_clk;
        if (init_rate > 0) cnt_init_wr = (int'($urandom_range(99)) < init_rate);
        if (stop_rate > 0) start = (int'($urandom_range(99)) >= stop_rate);
        if (rst_rate > 0) rst = (int'($urandom_range(999)) < rst_rate);
        model_step();
        exp_q.push_back(obs_t'{m_count, m_dir, m_ovf, m_m0, m_m1, m_out ^ inv});
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive_cycle();
    endtask

    task automatic cfg(input logic mode, input logic sel, input logic edg, input logic ff,
                       input int presc, input int mn, input int mx, input int m0v,
                       input int m1v, input logic pwm, input logic iv);
        count_mode   = mode;
        clock_select = sel;
        edge_mode    = edg;
        force_free   = ff;
        prescaler    = PB'(presc);
        count_min    = CW'(mn);
        count_max    = CW'(mx);
        match0       = CW'(m0v);
        match1       = CW'(m1v);
        pwm_mode     = pwm;
        inv          = iv;
        start        = 1'b1;
        rst          = 1'b0;
        cnt_init_wr  = 1'b0;
        pin_rate     = 0;
        init_rate    = 0;
        stop_rate    = 0;
        rst_rate     = 0;
    endtask

    // Monitor.
    initial begin
        obs_t e, g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                g = '{count, dir, overflow, match_0, match_1, tmr_out};
                checks++;
                if (g !== e) begin
                    failures++;
                    $display({"FAIL scoreboard t=%0t got cnt=%h dir=%b ovf=%b m0=%b m1=%b out=%b",
                              " want cnt=%h dir=%b ovf=%b m0=%b m1=%b out=%b"},
                             $time, g.count, g.dir, g.ovf, g.m0, g.m1, g.tout,
                             e.count, e.dir, e.ovf, e.m0, e.m1, e.tout);
                end
            end
        end
    end

    // Driver.
    initial begin
        int mn, mx;
        @(negedge clk);
        rst = 1'b1;
        run(3);

        // Up, internal clock, range 2..5.
        cfg(1'b0, 1'b0, 1'b0, 1'b0, 0, 2, 5, 4, 3, 1'b0, 1'b0);
        run(20);

        // Up/down 0..3, divide by 2.
        cfg(1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 3, 2, 0, 1'b0, 1'b0);
        run(30);

        // Degenerate up/down range.
        cfg(1'b1, 1'b0, 1'b0, 1'b0, 0, 3, 3, 3, 4, 1'b0, 1'b0);
        run(6);

        // External falling edges; rising edges must not count.
        cfg(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1000, 2000, 2000, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            ext_clk = ~ext_clk;
            run(6);
        end
        pin_rate = 40;
        run(60);

        // Load collides with a tick.
        cfg(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 256, 'h41, 'h40, 1'b0, 1'b0);
        run(5);
        count_init  = 'h40;
        cnt_init_wr = 1'b1;
        run(1);
        cnt_init_wr = 1'b0;
        run(5);

        // PWM 0..9, duty 3/10, both polarities.
        cfg(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 9, 3, 9, 1'b1, 1'b0);
        run(35);
        inv = 1'b1;
        run(35);

        // Reset mid-run at count 7.
        cfg(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 20, 9, 7, 1'b0, 1'b1);
        for (int i = 0; i < 40 && m_count != 7; i++) drive_cycle();
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(10);

        // Free-running wrap at the full-range top, up then up/down.
        cfg(1'b0, 1'b0, 1'b0, 1'b1, 0, 5, 9, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        count_init  = 32'hFFFF_FFFD;
        cnt_init_wr = 1'b1;
        run(1);
        cnt_init_wr = 1'b0;
        run(6);
        count_mode  = 1'b1;
        count_init  = 32'hFFFF_FFFD;
        cnt_init_wr = 1'b1;
        run(1);
        cnt_init_wr = 1'b0;
        run(8);

        // Randomised configurations with random loads, stalls, pin activity and resets.
        for (int ph = 0; ph < 30; ph++) begin
            mn = int'($urandom_range(6));
            mx = mn + int'($urandom_range(10));
            cfg(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                ($urandom_range(7) == 0), int'($urandom_range(3)), mn, mx,
                int'($urandom_range(mx + 1)), int'($urandom_range(mx + 1)),
                1'($urandom_range(1)), 1'($urandom_range(1)));
            if (ph % 7 == 6) prescaler = PB'(7);
            count_init = force_free ? 32'hFFFF_FFFF - $urandom_range(3) : $urandom_range(mx + 2);
            pin_rate   = clock_select ? 35 : 10;
            init_rate  = 3;
            stop_rate  = 5;
            rst_rate   = 5;
            run(60);
        end
        rst_rate    = 0;
        rst         = 1'b0;
        cnt_init_wr = 1'b0;

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected outputs never compared, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
